// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the reservoir matrix-vector MAC.
// Holds the FSM state encoding, accumulator sizing and output width conversion.
package reservoir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    function automatic int acc_width_f(input int data_width, input int weight_size, input int n);
        return data_width + weight_size + $clog2(n);
    endfunction

    // Saturating clamp or plain pass-through; the caller keeps the low out_width bits.
    function automatic logic signed [31:0] convert_out(input logic signed [31:0] acc,
                                                       input int out_width,
                                                       input bit sat_mode);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_width - 1));
        if (sat_mode && (acc > hi)) return hi;
        if (sat_mode && (acc < lo)) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/reservoir_row_dot.sv
// Combinational signed dot product of one weight row with the state vector.
// Zero latency; no handshake, the caller holds operands stable.
module reservoir_row_dot #(
    parameter int data_width     = 3,
    parameter int weight_size    = 2,
    parameter int reservoir_size = 4,
    parameter int acc_width      = 7
) (
    input  logic [reservoir_size*data_width-1:0]  data,
    input  logic [reservoir_size*weight_size-1:0] weights,
    output logic signed [acc_width-1:0]           sum
);

    logic signed [acc_width-1:0] d_ext;
    logic signed [acc_width-1:0] w_ext;

    // Operands are sign-extended to acc_width so every product and the sum stay exact.
    always_comb begin
        sum   = '0;
        d_ext = '0;
        w_ext = '0;
        for (int c = 0; c < reservoir_size; c++) begin
            d_ext = acc_width'(signed'(data[c*data_width +: data_width]));
            w_ext = acc_width'(signed'(weights[c*weight_size +: weight_size]));
            sum   = sum + d_ext * w_ext;
        end
    end

endmodule

// File: rtl/reservoir_mac.sv
// Signed NxN matrix-vector MAC, one output row per clock, saturate or wrap on output.
// Latency N+1 cycles accept-to-valid; result held in DONE until iReady, oReady low while busy.
module reservoir_mac
    import reservoir_pkg::*;
#(
    parameter int data_width     = 3,
    parameter int weight_size    = 2,
    parameter int reservoir_size = 4,
    parameter int out_width      = 8,
    parameter bit sat_mode       = 1'b1
) (
    input  logic                                          iClk,
    input  logic                                          iRst_n,
    input  logic                                          iWeWeight,
    input  logic [$clog2(reservoir_size*reservoir_size)-1:0] iWeightAddr,
    input  logic [weight_size-1:0]                        iWeight,
    input  logic                                          iValid,
    output logic                                          oReady,
    input  logic [reservoir_size*data_width-1:0]          iData,
    output logic                                          oValid,
    input  logic                                          iReady,
    output logic [reservoir_size*out_width-1:0]           oValue,
    output logic                                          oBusy
);

    localparam int N         = reservoir_size;
    localparam int acc_width = acc_width_f(data_width, weight_size, reservoir_size);
    localparam int row_width = $clog2(N);

    state_t                         state;
    logic [row_width-1:0]           row;
    logic [N*data_width-1:0]        x_reg;
    logic [N*N*weight_size-1:0]     w_flat;
    logic [N*out_width-1:0]         result;
    logic [N*weight_size-1:0]       row_w;
    logic signed [acc_width-1:0]    acc;
    logic signed [31:0]             conv_full;
    logic [out_width-1:0]           conv;
    logic                           conv_unused;
    logic                           addr_ok;

    // N*N need not be a power of two, so the top of the address space may be unmapped.
    assign addr_ok = int'(iWeightAddr) < N * N;

    always_comb begin
        row_w = '0;
        for (int c = 0; c < N; c++) begin
            row_w[c*weight_size +: weight_size] =
                w_flat[(int'(row) * N + c) * weight_size +: weight_size];
        end
    end

    reservoir_row_dot #(
        .data_width     (data_width),
        .weight_size    (weight_size),
        .reservoir_size (reservoir_size),
        .acc_width      (acc_width)
    ) u_row_dot (
        .data    (x_reg),
        .weights (row_w),
        .sum     (acc)
    );

    assign conv_full   = convert_out(32'(acc), out_width, sat_mode);
    assign conv        = conv_full[out_width-1:0];
    assign conv_unused = ^conv_full[31:out_width];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            row    <= '0;
            x_reg  <= '0;
            w_flat <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iWeWeight && addr_ok) begin
                        w_flat[int'(iWeightAddr) * weight_size +: weight_size] <= iWeight;
                    end
                    if (iValid) begin
                        x_reg <= iData;
                        row   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    result[int'(row) * out_width +: out_width] <= conv;
                    if (row == row_width'(N - 1)) begin
                        state <= DONE;
                    end else begin
                        row <= row + row_width'(1);
                    end
                end
                DONE: begin
                    if (iReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oReady = (state == IDLE);
    assign oBusy  = (state != IDLE);
    assign oValid = (state == DONE);
    assign oValue = result;

endmodule
